// File: rtl/trigger_conditioner.sv
// Conditions the raw trigger button into the clean level the CPU reads as x5.
// Signal path: synchroniser, then a debounce FSM, then the trigger latch.
module trigger_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16,
    parameter bit LATCH_MODE      = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    input  logic       clr,
    output logic       trigger,
    output logic       press,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        IDLE,
        RISE_WAIT,
        HIGH,
        FALL_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state, state_next;
    logic [CNT_W-1:0]       cnt, cnt_next;
    logic                   press_set;
    logic                   level_next;

    // Metastability chain; only its last stage feeds the debouncer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // An edge is accepted only after the synchronised level stays put long enough.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        press_set  = 1'b0;
        unique case (state)
            IDLE: begin
                if (s) begin
                    state_next = RISE_WAIT;
                    cnt_next   = '0;
                end
            end
            RISE_WAIT: begin
                if (!s) begin
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_next = HIGH;
                    press_set  = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!s) begin
                    state_next = FALL_WAIT;
                    cnt_next   = '0;
                end
            end
            FALL_WAIT: begin
                if (s) begin
                    state_next = HIGH;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign level_next = (state_next == HIGH) || (state_next == FALL_WAIT);

    // Set takes priority over clr so a press coinciding with an acknowledge is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press       <= 1'b0;
            press_count <= 8'd0;
            trigger     <= 1'b0;
        end else begin
            press <= press_set;
            if (press_set) begin
                press_count <= press_count + 8'd1;
            end
            if (LATCH_MODE) begin
                if (press_set) begin
                    trigger <= 1'b1;
                end else if (clr) begin
                    trigger <= 1'b0;
                end
            end else begin
                trigger <= level_next;
            end
        end
    end

endmodule

// File: tb/tb_trigger_conditioner.sv
// Bench for trigger_conditioner: latched and level-following instances share one button,
// with expected presses queued by the stimulus and checked by an independent monitor.
module tb_trigger_conditioner;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int LAT  = SYNC + DEB + 1;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       btn_in = 1'b1;
    logic       clr    = 1'b0;
    logic       trigger, press;
    logic [7:0] press_count;
    logic       trigger0, press0;
    logic [7:0] press_count0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         at;
        logic [7:0] cnt;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] exp_cnt = 8'd0;

    trigger_conditioner #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(16), .LATCH_MODE(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .clr(clr),
        .trigger(trigger), .press(press), .press_count(press_count)
    );

    trigger_conditioner #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(16), .LATCH_MODE(1'b0)
    ) dut0 (
        .clk(clk), .rst(rst), .btn_in(btn_in), .clr(clr),
        .trigger(trigger0), .press(press0), .press_count(press_count0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic expectPress();
        exp_t e;
        exp_cnt = exp_cnt + 8'd1;
        e.at    = cyc + LAT;
        e.cnt   = exp_cnt;
        expq.push_back(e);
    endtask

    task automatic applyStimulus(input logic b, input int n);
        btn_in = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic cleanPress();
        expectPress();
        applyStimulus(1'b1, LAT + 3);
    endtask

    task automatic cleanRelease();
        applyStimulus(1'b0, LAT + 3);
    endtask

    task automatic pulseClr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // Scoreboard monitor: every press pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (expq.size() > 0 && expq[0].at < cyc) begin
                checkOutput("missed press cycle", cyc, expq[0].at);
                void'(expq.pop_front());
            end
            if (press) begin
                if (expq.size() == 0) begin
                    checkOutput("spurious press", press, 0);
                end else begin
                    e = expq.pop_front();
                    checkOutput("press cycle", cyc, e.at);
                    checkOutput("press_count", press_count, e.cnt);
                    checkOutput("trigger at press", trigger, 1);
                    checkOutput("mode0 press", press0, 1);
                    checkOutput("mode0 trigger at press", trigger0, 1);
                    checkOutput("mode0 press_count", press_count0, e.cnt);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset held with the button already pressed.
        #12;
        checkOutput("reset trigger", trigger, 0);
        checkOutput("reset press", press, 0);
        checkOutput("reset press_count", press_count, 0);
        checkOutput("reset mode0 trigger", trigger0, 0);
        @(negedge clk);
        rst = 1'b0;
        expectPress();
        applyStimulus(1'b1, LAT + 3);
        cleanRelease();
        checkOutput("trigger held after release", trigger, 1);
        checkOutput("mode0 trigger after release", trigger0, 0);

        // Acknowledge, then an acknowledge with nothing pending.
        pulseClr();
        checkOutput("trigger cleared by clr", trigger, 0);
        pulseClr();
        checkOutput("clr with trigger low", trigger, 0);
        checkOutput("count after clr", press_count, 1);

        // Bouncy press never reaches the debounce threshold.
        applyStimulus(1'b1, 3);
        applyStimulus(1'b0, 1);
        applyStimulus(1'b1, 3);
        applyStimulus(1'b0, LAT + 3);
        checkOutput("bounce trigger", trigger, 0);
        checkOutput("bounce press_count", press_count, 1);

        cleanPress();
        cleanRelease();
        checkOutput("second press trigger", trigger, 1);
        pulseClr();
        checkOutput("second clr", trigger, 0);

        // clr sampled on the same edge that accepts the press.
        expectPress();
        btn_in = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("set wins over clr", trigger, 1);

        // Short release while held must not produce another press.
        applyStimulus(1'b0, 2);
        applyStimulus(1'b1, LAT + 5);
        checkOutput("release bounce count", press_count, 3);
        checkOutput("release bounce mode0 trigger", trigger0, 1);
        cleanRelease();

        // Level-following instance ignores clr and drops LAT edges after release.
        cleanPress();
        pulseClr();
        checkOutput("mode0 ignores clr", trigger0, 1);
        checkOutput("latched cleared while held", trigger, 0);
        btn_in = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        checkOutput("mode0 trigger before drop", trigger0, 1);
        @(negedge clk);
        checkOutput("mode0 trigger dropped", trigger0, 0);
        repeat (3) @(negedge clk);

        // Run presses until 256 have been accepted since reset.
        do begin
            cleanPress();
            cleanRelease();
        end while (exp_cnt != 8'd0);
        checkOutput("press_count wrapped", press_count, 0);
        checkOutput("mode0 press_count wrapped", press_count0, 0);

        // Asynchronous reset in the middle of a debounce window.
        cleanPress();
        cleanRelease();
        btn_in = 1'b1;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("async reset trigger", trigger, 0);
        checkOutput("async reset press_count", press_count, 0);
        checkOutput("async reset press", press, 0);
        checkOutput("async reset mode0 trigger", trigger0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 8'd0;
        expectPress();
        repeat (LAT + 3) @(negedge clk);
        cleanRelease();
        checkOutput("pending presses", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
